// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep controller.
package counter_sweep_pkg;

  // Default datapath widths; the top exposes these as parameters.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  // Counter direction encoding as seen on updn_cnt.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Sweep FSM states. DWELL_HI/DWELL_LO are only reachable when the
  // dwell feature is built in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    UP       = 3'd2,
    DOWN     = 3'd3,
    DWELL_HI = 3'd4,
    DWELL_LO = 3'd5
  } state_e;

endpackage : counter_sweep_pkg

// File: rtl/counter_sweep_dwell_timer.sv
// Loadable down-counter used to hold the sweep at each turning point.
// done is high while the count is zero; load has priority over counting.
module counter_sweep_dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // Next count: reload, otherwise decrement until zero and stay there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule : counter_sweep_dwell_timer

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for the loadable up/down counter: loads lo, counts up to
// hi, back down to lo, and repeats, reporting each completed period.
// Optional build macro COUNTER_SWEEP_DWELL_EN adds a DWELL-cycle hold at
// each turning point.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic [WIDTH-1:0] cnt_value,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             cfg_err,
  output logic             resync,
  output logic             sweep_done,
  output logic [CNT_W-1:0] sweep_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             updn_q, updn_d;
  logic             first_q, first_d;
  logic             cfg_err_q, cfg_err_d;
  logic             resync_q, resync_d;
  logic             sweep_done_q, sweep_done_d;
  logic             out_of_range;

`ifdef COUNTER_SWEEP_DWELL_EN
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic dwell_load;
  logic dwell_done;

  // Arm the timer on the edge that enters a dwell state, so that dwell
  // lasts exactly DWELL cycles.
  assign dwell_load = ((state_d == DWELL_HI) || (state_d == DWELL_LO)) &&
                      (state_d != state_q);

  counter_sweep_dwell_timer #(
    .W (DW_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val (DW_W'(DWELL - 1)),
    .done     (dwell_done)
  );
`endif

  assign out_of_range = (cnt_value < lo_q) || (cnt_value > hi_q);

  // Next-state, limit latching, sweep counting and event pulses.
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    sweep_cnt_d  = sweep_cnt_q;
    cfg_err_d    = 1'b0;
    resync_d     = 1'b0;
    sweep_done_d = 1'b0;
    first_d      = (state_q == LOAD);

    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (hi_limit > lo_limit) begin
              lo_d        = lo_limit;
              hi_d        = hi_limit;
              sweep_cnt_d = '0;
              state_d     = LOAD;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        LOAD: state_d = UP;
        UP: begin
          // The cycle right after a load is trusted without a range check.
          if (!first_q && out_of_range) begin
            resync_d = 1'b1;
            state_d  = LOAD;
          end else if (cnt_value == hi_q - WIDTH'(1)) begin
`ifdef COUNTER_SWEEP_DWELL_EN
            state_d = DWELL_HI;
`else
            state_d = DOWN;
`endif
          end
        end
        DOWN: begin
          if (out_of_range) begin
            resync_d = 1'b1;
            state_d  = LOAD;
          end else if (cnt_value == lo_q + WIDTH'(1)) begin
`ifdef COUNTER_SWEEP_DWELL_EN
            state_d = DWELL_LO;
`else
            state_d      = UP;
            sweep_done_d = 1'b1;
            if (sweep_cnt_q != '1) sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
`endif
          end
        end
`ifdef COUNTER_SWEEP_DWELL_EN
        DWELL_HI: begin
          if (dwell_done) state_d = DOWN;
        end
        DWELL_LO: begin
          if (dwell_done) begin
            state_d      = UP;
            sweep_done_d = 1'b1;
            if (sweep_cnt_q != '1) sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    // Direction follows the counting state and holds everywhere else,
    // which keeps it steady through dwell and load.
    updn_d = updn_q;
    if (state_d == UP)   updn_d = DIR_UP;
    if (state_d == DOWN) updn_d = DIR_DN;
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      sweep_cnt_q  <= '0;
      updn_q       <= DIR_UP;
      first_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
      resync_q     <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      sweep_cnt_q  <= sweep_cnt_d;
      updn_q       <= updn_d;
      first_q      <= first_d;
      cfg_err_q    <= cfg_err_d;
      resync_q     <= resync_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Moore outputs decoded from registered state only.
  assign data_in    = lo_q;
  assign ld_cnt     = (state_q != LOAD);
  assign count_enb  = (state_q == UP) || (state_q == DOWN);
  assign updn_cnt   = updn_q;
  assign busy       = (state_q != IDLE);
  assign cfg_err    = cfg_err_q;
  assign resync     = resync_q;
  assign sweep_done = sweep_done_q;
  assign sweep_cnt  = sweep_cnt_q;

endmodule : counter_sweep_ctrl

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural 16-bit
// up/down counter closing the loop. Honours COUNTER_SWEEP_DWELL_EN.
module tb_counter_sweep_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int DWELL = 4;
`ifdef COUNTER_SWEEP_DWELL_EN
  localparam int DW = DWELL;
`else
  localparam int DW = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] lo_limit = '0;
  logic [WIDTH-1:0] hi_limit = '0;
  logic [WIDTH-1:0] cnt_value;
  logic [WIDTH-1:0] data_in;
  logic             ld_cnt, updn_cnt, count_enb, busy;
  logic             cfg_err, resync, sweep_done;
  logic [CNT_W-1:0] sweep_cnt;

  logic [WIDTH-1:0] model_cnt;
  logic             disturb = 1'b0;

  int n_checks = 0;
  int n_bad    = 0;

  counter_sweep_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .lo_limit   (lo_limit),
    .hi_limit   (hi_limit),
    .cnt_value  (cnt_value),
    .data_in    (data_in),
    .ld_cnt     (ld_cnt),
    .updn_cnt   (updn_cnt),
    .count_enb  (count_enb),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .resync     (resync),
    .sweep_done (sweep_done),
    .sweep_cnt  (sweep_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream counter (active-low load).
  always @(posedge clk or negedge rst) begin
    if (!rst)            model_cnt <= '0;
    else if (!ld_cnt)    model_cnt <= data_in;
    else if (count_enb)  model_cnt <= updn_cnt ? model_cnt + 16'd1 : model_cnt - 16'd1;
  end

  assign cnt_value = disturb ? 16'd50 : model_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue an accepted start, check the single LOAD cycle, and return on
  // the negedge of the first UP cycle.
  task automatic start_sweep(input int lo, input int hi);
    lo_limit = WIDTH'(lo);
    hi_limit = WIDTH'(hi);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("load_ld", ld_cnt, 0);
    check("load_enb", count_enb, 0);
    check("load_data", data_in, lo);
    check("load_busy", busy, 1);
    tick();
  endtask

  // Walk n cycles of the triangle from phase 0, comparing against the
  // hand-derived shape: up d cycles, dwell DW, down d cycles, dwell DW.
  task automatic run_sweep(input int lo, input int hi, input int n);
    int d, p, ph, e_cnt, e_up, e_enb;
    d = hi - lo;
    p = 2 * d + 2 * DW;
    for (int k = 0; k <= n; k++) begin
      ph = k % p;
      if (ph < d)               begin e_cnt = lo + ph;            e_up = 1; e_enb = 1; end
      else if (ph < d + DW)     begin e_cnt = hi;                 e_up = 1; e_enb = 0; end
      else if (ph < 2 * d + DW) begin e_cnt = hi - (ph - d - DW); e_up = 0; e_enb = 1; end
      else                      begin e_cnt = lo;                 e_up = 0; e_enb = 0; end
      check("cnt", cnt_value, e_cnt);
      check("updn", updn_cnt, e_up);
      check("enb", count_enb, e_enb);
      check("done", sweep_done, (k > 0 && ph == 0) ? 1 : 0);
      if (k < n) tick();
    end
  endtask

  initial begin
    // Reset held for 3 clocks.
    repeat (3) @(posedge clk);
    tick();
    check("rst_ld", ld_cnt, 1);
    check("rst_enb", count_enb, 0);
    check("rst_updn", updn_cnt, 1);
    check("rst_data", data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {cfg_err, resync, sweep_done}, 0);
    check("rst_scnt", sweep_cnt, 0);
    rst = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Basic sweep lo=4 hi=8, three full periods.
    start_sweep(4, 8);
    run_sweep(4, 8, 3 * (2 * 4 + 2 * DW));
    check("basic_scnt", sweep_cnt, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop1_busy", busy, 0);
    check("stop1_scnt", sweep_cnt, 3);

    // Narrow limits: turnaround every cycle.
    start_sweep(10, 11);
    check("narrow_scnt0", sweep_cnt, 0);
    run_sweep(10, 11, 4 * (2 + 2 * DW));
    check("narrow_scnt", sweep_cnt, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Rejected configurations.
    lo_limit = 16'd20; hi_limit = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_eq_err", cfg_err, 1);
    check("cfg_eq_busy", busy, 0);
    check("cfg_eq_ld", ld_cnt, 1);
    tick();
    check("cfg_eq_pulse", cfg_err, 0);
    lo_limit = 16'd20; hi_limit = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_lt_err", cfg_err, 1);
    check("cfg_lt_busy", busy, 0);
    tick();
    check("cfg_lt_pulse", cfg_err, 0);
    check("cfg_lt_ld", ld_cnt, 1);

    // Disturbance during UP forces a resync and reload.
    start_sweep(4, 8);
    tick();
    tick();
    check("dist_pre", cnt_value, 6);
    disturb = 1'b1;
    tick();
    disturb = 1'b0;
    check("dist_resync", resync, 1);
    check("dist_ld", ld_cnt, 0);
    check("dist_data", data_in, 4);
    tick();
    check("dist_resync_clr", resync, 0);
    run_sweep(4, 8, 2 * 4 + 2 * DW);
    check("dist_scnt", sweep_cnt, 1);

    // stop together with start: stop wins, both while busy and in IDLE.
    stop = 1'b1; start = 1'b1;
    tick();
    check("stop_busy", busy, 0);
    check("stop_enb", count_enb, 0);
    check("stop_scnt", sweep_cnt, 1);
    tick();
    check("stop_idle_busy", busy, 0);
    check("stop_idle_ld", ld_cnt, 1);
    stop = 1'b0; start = 1'b0;
    tick();

    // Asynchronous reset mid-sweep abandons at once.
    start_sweep(4, 8);
    tick();
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_enb", count_enb, 0);
    check("arst_done", sweep_done, 0);
    tick();
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_counter_sweep_ctrl
